// File: rtl/alu_multiciclo.sv
// Registered ALU with start/done handshake: single-cycle logic/arith ops plus
// iterative unsigned multiply (shift-add) and divide/remainder (restoring).
module alu_multiciclo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_resultado,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned     CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic {IDLE, ITER} state_t;

    state_t           state, state_n;
    logic             pend, pend_n;
    logic [3:0]       op, op_n;
    logic [WIDTH-1:0] opa, opa_n;
    logic [WIDTH-1:0] opb, opb_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] lo, lo_n;
    logic             busy_n, done_n, zero_n, cy_n, ov_n;
    logic [WIDTH-1:0] res_n;

    logic [WIDTH:0]   sum_add, sum_sub;
    logic             ovf_add, ovf_sub, slt;
    logic             is_iter;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_n, mul_lo_n;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_acc_n, div_lo_n;

    always_comb begin
        sum_add = {1'b0, opa} + {1'b0, opb};
        sum_sub = {1'b0, opa} + {1'b0, ~opb} + (WIDTH+1)'(1);
        ovf_add = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum_add[WIDTH-1] != opa[WIDTH-1]);
        ovf_sub = (opa[WIDTH-1] != opb[WIDTH-1]) && (sum_sub[WIDTH-1] != opa[WIDTH-1]);
        slt     = sum_sub[WIDTH-1] ^ ovf_sub;
        is_iter = (alu_control == OP_MULU) || (alu_control == OP_DIVU) ||
                  (alu_control == OP_REMU);
    end

    // Multiply: acc holds the high half, lo the multiplier shifting out LSB-first.
    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opa} : '0);
        mul_acc_n = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], lo[WIDTH-1:1]};
    end

    // Divide: acc is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        div_sh    = {acc, lo[WIDTH-1]};
        div_ge    = div_sh >= {1'b0, opb};
        div_acc_n = div_ge ? (div_sh[WIDTH-1:0] - opb) : div_sh[WIDTH-1:0];
        div_lo_n  = {lo[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_n = state;
        pend_n  = pend;
        op_n    = op;
        opa_n   = opa;
        opb_n   = opb;
        cnt_n   = cnt;
        acc_n   = acc;
        lo_n    = lo;
        busy_n  = busy;
        done_n  = 1'b0;
        res_n   = out_resultado;
        zero_n  = zero;
        cy_n    = carry_out;
        ov_n    = overflow;

        // Single-cycle ops latch operands on the start edge and retire one edge later.
        if (pend) begin
            pend_n = 1'b0;
            done_n = 1'b1;
            cy_n   = 1'b0;
            ov_n   = 1'b0;
            case (op)
                OP_AND: res_n = opa & opb;
                OP_OR:  res_n = opa | opb;
                OP_NOR: res_n = ~(opa | opb);
                OP_ADD: begin
                    res_n = sum_add[WIDTH-1:0];
                    cy_n  = sum_add[WIDTH];
                    ov_n  = ovf_add;
                end
                OP_SUB: begin
                    res_n = sum_sub[WIDTH-1:0];
                    cy_n  = sum_sub[WIDTH];
                    ov_n  = ovf_sub;
                end
                OP_SLT:  res_n = {{(WIDTH-1){1'b0}}, slt};
                default: res_n = '0;
            endcase
        end

        case (state)
            IDLE: begin
                if (start) begin
                    op_n  = alu_control;
                    opa_n = a;
                    opb_n = b;
                    if (is_iter) begin
                        cnt_n   = '0;
                        acc_n   = '0;
                        lo_n    = (alu_control == OP_MULU) ? b : a;
                        busy_n  = 1'b1;
                        state_n = ITER;
                    end else begin
                        pend_n = 1'b1;
                    end
                end
            end
            ITER: begin
                cnt_n = cnt + CW'(1);
                if (op == OP_MULU) begin
                    acc_n = mul_acc_n;
                    lo_n  = mul_lo_n;
                end else begin
                    acc_n = div_acc_n;
                    lo_n  = div_lo_n;
                end
                if (cnt == LAST) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    case (op)
                        OP_MULU: begin
                            res_n = mul_lo_n;
                            cy_n  = |mul_acc_n;
                            ov_n  = |mul_acc_n;
                        end
                        OP_DIVU: begin
                            res_n = div_lo_n;
                            cy_n  = 1'b0;
                            ov_n  = (opb == '0);
                        end
                        default: begin
                            res_n = div_acc_n;
                            cy_n  = 1'b0;
                            ov_n  = (opb == '0);
                        end
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase

        if (done_n) begin
            zero_n = (res_n == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pend          <= 1'b0;
            op            <= '0;
            opa           <= '0;
            opb           <= '0;
            cnt           <= '0;
            acc           <= '0;
            lo            <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            out_resultado <= '0;
            zero          <= 1'b0;
            carry_out     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_n;
            pend          <= pend_n;
            op            <= op_n;
            opa           <= opa_n;
            opb           <= opb_n;
            cnt           <= cnt_n;
            acc           <= acc_n;
            lo            <= lo_n;
            busy          <= busy_n;
            done          <= done_n;
            out_resultado <= res_n;
            zero          <= zero_n;
            carry_out     <= cy_n;
            overflow      <= ov_n;
        end
    end

endmodule

// File: doc/alu_multiciclo.md
# alu_multiciclo

Parametrised, registered ALU with a start/done handshake. It is the sequential successor of the 32-bit combinational ALU. It keeps the existing opcode map and flag set (AND, OR, ADD, SUB, SLT, NOR with zero/carry_out/overflow) and adds iterative unsigned multiply, divide and remainder. It sits between the datapath register file and the writeback mux; the control FSM holds writeback until `done`.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; legal values ≥ 4.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `alu_control`  in  4  opcode, latched with `start`.
- `a`  in  WIDTH  operand A, latched with `start`.
- `b`  in  WIDTH  operand B, latched with `start`.
- `busy`  out  1  iterative op in progress.
- `done`  out  1  one-cycle pulse; result and flags valid from this cycle on.
- `out_resultado`  out  WIDTH  result; holds until the next `done`.
- `zero`  out  1  `out_resultado` == 0.
- `carry_out`  out  1  see Operation.
- `overflow`  out  1  see Operation.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 1100 NOR: bitwise; carry_out=0, overflow=0.
  - 0010 ADD: (WIDTH+1)-bit sum. carry_out = bit WIDTH. overflow = signed overflow (operands same sign, result sign differs).
  - 0110 SUB: a + ~b + 1. carry_out = 1 iff a ≥ b unsigned (no borrow). overflow = signed overflow (operand signs differ, result sign ≠ sign of a).
  - 0111 SLT: result = 1 if a < b signed, else 0. Computed from sign(a−b) XOR signed-overflow, so it is correct at extremes. carry_out=0, overflow=0.
  - 1000 MULU: shift-add, low WIDTH bits of the unsigned product. carry_out = overflow = 1 iff the high WIDTH bits ≠ 0.
  - 1001 DIVU: restoring division; result = quotient.
  - 1010 REMU: restoring division; result = remainder.
  - DIVU/REMU with b=0: quotient all-ones, remainder = a, overflow=1, carry_out=0. The op still takes full latency.
  - Any other opcode: result 0, zero=1, carry_out=0, overflow=0, single-cycle.
- `zero` is registered together with `out_resultado` for every opcode.
- FSM states: IDLE, ITER.
  - IDLE + start + single-cycle opcode: compute, register result/flags, pulse `done` next cycle. Stay IDLE.
  - IDLE + start + 1000/1001/1010: latch operands, clear the accumulator, load the step counter (`$clog2(WIDTH)`+1 bits) with 0. Set busy=1 and go to ITER.
  - ITER: one shift-add or shift-subtract step per cycle, counter +1. When counter reaches WIDTH−1 on the current edge, the final step writes result and flags, sets done=1, busy=0, and returns to IDLE.
- Operands are latched; `a`, `b` and `alu_control` may change freely after the start edge.
- `start` during ITER is ignored (not queued).

## Timing
- Reset (async, any time, including mid-ITER):
  - state=IDLE, busy=0, done=0, out_resultado=0, zero=0, carry_out=0, overflow=0.
  - Counter, accumulators and latched operands are cleared.
  - The aborted op produces no `done`.
- First `start` is accepted on the first rising edge with rst_n=1.
- Single-cycle ops: `start` sampled at edge N; done=1 and result valid after edge N+1. Latency 1, throughput 1 per cycle; back-to-back starts give consecutive done pulses.
- Iterative ops: `start` sampled at edge N (busy=1 after it). WIDTH steps occur at edges N+1 … N+WIDTH. done=1 and busy=0 after edge N+WIDTH. Latency WIDTH cycles.
- A new `start` is accepted in the same cycle that `done` is high (busy already 0). Back-to-back MULU throughput: one result per WIDTH+1 cycles.
- `done` is high for exactly one cycle per accepted start; outputs are stable between done pulses.

## Test plan
- ADD/SUB flags (WIDTH=32):
  - 0x7FFFFFFF+1 → 0x80000000, overflow=1, carry=0.
  - 0xFFFFFFFF+1 → 0, zero=1, carry=1.
  - SUB 50−100 → 0xFFFFFFCE, carry=0, overflow=0.
  - SUB 200−150 → 50, carry=1.
- Logic/SLT, each done 1 cycle after start:
  - AND 0xFFFF0000,0x0F0F0F0F → 0x0F0F0000.
  - NOR 0xAAAA5555,0x5555AAAA → 0, zero=1.
  - SLT 0x80000000,1 → 1.
  - SLT 30,50 → 1.
- MULU:
  - 1234×5678 → 7006652, carry=overflow=0, done exactly 32 cycles after the start edge, busy high for those 32 cycles.
  - 0x10000×0x10000 → 0, zero=1, carry=overflow=1.
- DIVU/REMU:
  - DIVU 200/7 → 28; REMU 200/7 → 4.
  - DIVU 5/0 → 0xFFFFFFFF, overflow=1; REMU 5/0 → 5.
- Start while busy: a second start with ADD issued 5 cycles into a MULU is ignored; only the MULU done appears. A start in the done cycle is accepted.
- Reset mid-op: rst_n low 10 cycles into a DIVU → all outputs 0 immediately (asynchronous), no done. After release, ADD 3+4 → 7 with done 1 cycle later.
- Parametrisation: rerun MULU and DIVU with WIDTH=8. 15×17 → 255 in 8 cycles. 16×16 → 0, carry=1. DIVU 255/16 → 15.
